traffic_phase_sequencer: RTL and testbench
==========================================

Name: traffic_phase_sequencer

Overview:
- Parametrised successor to the intersection light FSM: steps through N_PHASES light phases using per-table phase durations.
- The duration table is selected from vehicle sensors, sampled once per cycle. Durations are run-time programmable.
- A pedestrian request latches and extends a designated phase. Selected phases wait for an external confirmation (for example, a red-check) before advancing.
- Contains its own 1-second prescaler, so no external chronometer is needed. Drives level light outputs directly, not toggle strobes.

Parameters:
- N_PHASES, 8, number of phases in one cycle (index width PW = clog2(N_PHASES)).
- N_LIGHTS, 9, number of light outputs.
- N_SENSORS, 3, vehicle sensor count. Table count is N_SENSORS+1 (index width TW).
- TIME_W, 8, phase duration width in seconds.
- TICKS_PER_SEC, 10000, CLK cycles per second (10 kHz).
- LIGHT_PATTERN, 0, flattened N_PHASES*N_LIGHTS vector. Phase p uses bits [p*N_LIGHTS +: N_LIGHTS].
- SAFE_LIGHTS, 0, pattern driven in IDLE.
- HOLD_MASK, 8'b1110_0000, bit p=1 means phase p waits for ext_ok.
- PED_PHASE, 4, phase extended by a pedestrian request.
- PED_EXTRA, 10, seconds added to PED_PHASE when a request is pending.
- DEFAULT_TIME, 3, reset value of every table entry.

Ports:
- CLK, in, 1: clock.
- reset_general_n, in, 1: asynchronous active-low reset.
- enable_general, in, 1: run enable.
- sensor, in, N_SENSORS: vehicle presence (synchronous to CLK).
- ped_button, in, 1: pedestrian request.
- ext_ok, in, 1: advance confirmation for hold phases.
- cfg_we, in, 1: table write strobe.
- cfg_table, in, TW: table index to write.
- cfg_phase, in, PW: phase index to write.
- cfg_time, in, TIME_W: duration in seconds.
- lights, out, N_LIGHTS: light levels.
- phase, out, PW: current phase.
- table_sel, out, TW: active table.
- remaining, out, TIME_W: whole seconds left in the phase.
- phase_start, out, 1: one-cycle pulse on the first cycle of each phase.
- ped_pending, out, 1: pedestrian request latched.
- running, out, 1: high in RUN.

Behaviour:
- **Reset (async, reset_general_n=0):**
  - state=IDLE, phase=0, table_sel=0, remaining=0, prescaler=0.
  - phase_start=0, ped_pending=0, running=0, lights=SAFE_LIGHTS.
  - All table entries = DEFAULT_TIME.
- **States:**
  - IDLE: lights=SAFE_LIGHTS.
  - RUN: lights = LIGHT_PATTERN slice of the current phase, registered.
- **IDLE to RUN:** on the first cycle with enable_general=1. This is a phase entry into phase 0.
- **RUN to IDLE:** on the next edge whenever enable_general=0, from any phase. phase returns to 0, ped_pending is kept, lights=SAFE_LIGHTS.
- **Phase entry (any phase p):**
  - prescaler=0, phase_start=1.
  - remaining = table[table_sel][p], plus PED_EXTRA if p==PED_PHASE and ped_pending=1.
  - The sum saturates at 2^TIME_W-1.
  - Entering PED_PHASE clears ped_pending.
- **Table select:** evaluated only on entry to phase 0. Sensor exactly one-hot with bit i set → table_sel=i+1. All-zero or multiple sensors → table_sel=0. Held constant for the rest of the cycle; mid-cycle sensor changes are ignored.
- **Timing:**
  - The prescaler counts 0..TICKS_PER_SEC-1. On wrap, remaining decrements; it never underflows.
  - done = (remaining==0) | (remaining==1 & prescaler==TICKS_PER_SEC-1).
  - Duration D>0 occupies exactly D*TICKS_PER_SEC cycles. D=0 occupies exactly 1 cycle.
- **Advance:** on done & (HOLD_MASK[p]==0 | ext_ok). Next phase is (p+1) mod N_PHASES; wrap to 0 re-runs table select.
- **Hold phases:** when done but ext_ok=0, stay in the phase with remaining=0 and the prescaler frozen. Advance on the edge where ext_ok=1 is sampled.
- **ped_button:** sampled each cycle. Sets ped_pending, which is sticky. A press on the same cycle as entry to PED_PHASE leaves ped_pending=1, so the request is served on the next cycle of the sequence.
- **Config writes:**
  - cfg_we writes table[cfg_table][cfg_phase] in one cycle; cfg_table > N_SENSORS is ignored.
  - A write never alters the running countdown; it takes effect on the next entry to that phase.
  - A write coincident with entry to the addressed phase loads the old value.

Test Plan:
1. TICKS_PER_SEC=4, all entries 3, no sensors, HOLD_MASK=0; release reset with enable_general=1 → phases 0..7 each last 12 cycles, phase_start pulses every 12 cycles, table_sel=0, lights follow LIGHT_PATTERN.
2. sensor=3'b010 held before the wrap to phase 0 → table_sel=2 for the cycle. Change sensor mid-cycle → table_sel unchanged until the next phase 0. sensor=3'b011 → table_sel=0.
3. Pulse ped_button in phase 1 with table entry for phase 4 = 5 → phase 4 lasts (5+10)*4=60 cycles and ped_pending clears on entry. Next cycle without a press → 20 cycles.
4. HOLD_MASK bit 5 set, ext_ok=0 → phase 5 sticks at remaining=0. Assert ext_ok 7 cycles later → advance to phase 6 one edge after.
5. Write cfg_table=0, cfg_phase=2, cfg_time=0 during phase 2 → current phase 2 unchanged. Next cycle phase 2 lasts 1 cycle. Entry 255 with ped extra → remaining saturates at 255.
6. Drop enable_general mid-phase 3 → IDLE and SAFE_LIGHTS on the next edge. Assert async reset mid-phase → all outputs at reset values immediately, table entries back to DEFAULT_TIME.

Source files
------------

// File: rtl/traffic_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : traffic_phase_sequencer
// Purpose  : Steps an intersection through N_PHASES light phases. Each phase
//            lasts a run-time programmable number of seconds, looked up in
//            one of N_SENSORS+1 duration tables. The table is chosen from the
//            vehicle sensors at the start of every cycle (phase 0 entry).
//            A pedestrian request is latched and stretches PED_PHASE. Phases
//            flagged in HOLD_MASK wait for ext_ok before advancing. An
//            internal prescaler derives the 1-second time base from CLK.
// Ports    : CLK             - clock
//            reset_general_n - asynchronous active-low reset
//            enable_general  - run enable (low returns to IDLE)
//            sensor          - vehicle presence, one bit per approach
//            ped_button      - pedestrian request (sticky once seen)
//            ext_ok          - advance confirmation for hold phases
//            cfg_we/cfg_table/cfg_phase/cfg_time - duration table write port
//            lights          - registered light levels
//            phase           - current phase index
//            table_sel       - active duration table
//            remaining       - whole seconds left in the current phase
//            phase_start     - one-cycle pulse on the first cycle of a phase
//            ped_pending     - pedestrian request latched
//            running         - high while sequencing
// Revision : 1.0 - initial release
// ============================================================================
module traffic_phase_sequencer #(
    parameter int                            N_PHASES      = 8,
    parameter int                            N_LIGHTS      = 9,
    parameter int                            N_SENSORS     = 3,
    parameter int                            TIME_W        = 8,
    parameter int                            TICKS_PER_SEC = 10000,
    parameter logic [N_PHASES*N_LIGHTS-1:0]  LIGHT_PATTERN = '0,
    parameter logic [N_LIGHTS-1:0]           SAFE_LIGHTS   = '0,
    parameter logic [N_PHASES-1:0]           HOLD_MASK     = 8'b1110_0000,
    parameter int                            PED_PHASE     = 4,
    parameter int                            PED_EXTRA     = 10,
    parameter int                            DEFAULT_TIME  = 3,
    localparam int                           PW = (N_PHASES > 1) ? $clog2(N_PHASES) : 1,
    localparam int                           TW = $clog2(N_SENSORS + 1)
) (
    input  logic                 CLK,
    input  logic                 reset_general_n,
    input  logic                 enable_general,
    input  logic [N_SENSORS-1:0] sensor,
    input  logic                 ped_button,
    input  logic                 ext_ok,
    input  logic                 cfg_we,
    input  logic [TW-1:0]        cfg_table,
    input  logic [PW-1:0]        cfg_phase,
    input  logic [TIME_W-1:0]    cfg_time,
    output logic [N_LIGHTS-1:0]  lights,
    output logic [PW-1:0]        phase,
    output logic [TW-1:0]        table_sel,
    output logic [TIME_W-1:0]    remaining,
    output logic                 phase_start,
    output logic                 ped_pending,
    output logic                 running
);

    localparam int                N_TABLES     = N_SENSORS + 1;
    localparam int                PSW          = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PSW-1:0]    c_PRES_LAST  = PSW'(TICKS_PER_SEC - 1);
    localparam logic [PW-1:0]     c_LAST_PHASE = PW'(N_PHASES - 1);
    localparam logic [PW-1:0]     c_PED_PHASE  = PW'(PED_PHASE);
    localparam logic [TIME_W-1:0] c_TIME_MAX   = '1;
    localparam logic [TIME_W-1:0] c_DEFAULT    = TIME_W'(DEFAULT_TIME);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t              r_state;
    logic [PW-1:0]       r_phase;
    logic [TW-1:0]       r_table_sel;
    logic [TIME_W-1:0]   r_remaining;
    logic [PSW-1:0]      r_prescaler;
    logic                r_phase_start;
    logic                r_ped_pending;
    logic                r_running;
    logic [N_LIGHTS-1:0] r_lights;
    logic [TIME_W-1:0]   r_table [N_TABLES][N_PHASES];

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [N_LIGHTS-1:0] w_pattern [N_PHASES];
    logic [TW-1:0]       w_sensor_sel;
    logic [TW-1:0]       w_onehot_idx;
    int                  w_sensor_hits;
    logic                w_cfg_table_ok;
    logic                w_cfg_phase_ok;
    logic                w_done;
    logic                w_hold_ok;
    logic                w_advance;
    logic                w_entry;
    logic [PW-1:0]       w_entry_phase;
    logic [TW-1:0]       w_entry_sel;
    logic [TIME_W-1:0]   w_base;
    logic                w_ped_hit;
    logic                w_ped_clear;
    logic [31:0]         w_sum;
    logic [TIME_W-1:0]   w_load;

    // Unpack the flattened light pattern into one word per phase.
    for (genvar gp = 0; gp < N_PHASES; gp++) begin : g_pattern
        assign w_pattern[gp] = LIGHT_PATTERN[gp*N_LIGHTS +: N_LIGHTS];
    end

    // Writes to a table or phase index that does not exist are dropped.
    // When the index width exactly covers the range the check is trivial.
    if (N_TABLES == (1 << TW)) begin : g_cfg_table_full
        assign w_cfg_table_ok = 1'b1;
    end else begin : g_cfg_table_part
        assign w_cfg_table_ok = (int'(cfg_table) < N_TABLES);
    end

    if (N_PHASES == (1 << PW)) begin : g_cfg_phase_full
        assign w_cfg_phase_ok = 1'b1;
    end else begin : g_cfg_phase_part
        assign w_cfg_phase_ok = (int'(cfg_phase) < N_PHASES);
    end

    // Exactly one sensor active selects table i+1; none or several select 0.
    always_comb begin
        w_sensor_hits = 0;
        w_onehot_idx  = '0;
        for (int i = 0; i < N_SENSORS; i++) begin
            if (sensor[i]) begin
                w_sensor_hits = w_sensor_hits + 1;
                w_onehot_idx  = TW'(i + 1);
            end
        end
        w_sensor_sel = (w_sensor_hits == 1) ? w_onehot_idx : '0;
    end

    // The phase is over on its last tick: either nothing is left, or the
    // final second is about to roll over on this cycle.
    assign w_done    = (r_remaining == '0) ||
                       ((r_remaining == TIME_W'(1)) && (r_prescaler == c_PRES_LAST));
    assign w_hold_ok = !HOLD_MASK[r_phase] || ext_ok;
    assign w_advance = (r_state == ST_RUN) && enable_general && w_done && w_hold_ok;
    assign w_entry   = ((r_state == ST_IDLE) && enable_general) || w_advance;

    // Phase being entered: leaving IDLE or wrapping the cycle both go to 0.
    assign w_entry_phase = ((r_state == ST_IDLE) || (r_phase == c_LAST_PHASE)) ?
                           '0 : (r_phase + PW'(1));

    // Table select is only re-evaluated on the way into phase 0.
    assign w_entry_sel = (w_entry_phase == '0) ? w_sensor_sel : r_table_sel;

    // Duration read uses the table contents before any same-cycle write,
    // so a coincident write only affects later entries.
    assign w_base      = r_table[w_entry_sel][w_entry_phase];
    assign w_ped_hit   = (w_entry_phase == c_PED_PHASE) && r_ped_pending;
    assign w_ped_clear = w_entry && (w_entry_phase == c_PED_PHASE);
    assign w_sum       = 32'(w_base) + (w_ped_hit ? 32'(PED_EXTRA) : 32'd0);
    assign w_load      = (w_sum > 32'(c_TIME_MAX)) ? c_TIME_MAX : w_sum[TIME_W-1:0];

    // ------------------------------------------------------------------
    // Duration tables
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge reset_general_n) begin
        if (!reset_general_n) begin
            for (int t = 0; t < N_TABLES; t++) begin
                for (int p = 0; p < N_PHASES; p++) begin
                    r_table[t][p] <= c_DEFAULT;
                end
            end
        end else if (cfg_we && w_cfg_table_ok && w_cfg_phase_ok) begin
            r_table[cfg_table][cfg_phase] <= cfg_time;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge reset_general_n) begin
        if (!reset_general_n) begin
            r_state       <= ST_IDLE;
            r_phase       <= '0;
            r_table_sel   <= '0;
            r_remaining   <= '0;
            r_prescaler   <= '0;
            r_phase_start <= 1'b0;
            r_ped_pending <= 1'b0;
            r_running     <= 1'b0;
            r_lights      <= SAFE_LIGHTS;
        end else begin
            r_phase_start <= w_entry;
            // A press on the very edge that serves the request re-arms it.
            r_ped_pending <= (r_ped_pending && !w_ped_clear) || ped_button;

            if (w_entry) begin
                r_state     <= ST_RUN;
                r_running   <= 1'b1;
                r_phase     <= w_entry_phase;
                r_table_sel <= w_entry_sel;
                r_remaining <= w_load;
                r_prescaler <= '0;
                r_lights    <= w_pattern[w_entry_phase];
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_running <= 1'b0;
                        r_lights  <= SAFE_LIGHTS;
                    end
                    ST_RUN: begin
                        if (!enable_general) begin
                            r_state     <= ST_IDLE;
                            r_running   <= 1'b0;
                            r_phase     <= '0;
                            r_remaining <= '0;
                            r_prescaler <= '0;
                            r_lights    <= SAFE_LIGHTS;
                        end else if (w_done) begin
                            // Waiting for ext_ok: time is up, prescaler frozen.
                            r_remaining <= '0;
                        end else if (r_prescaler == c_PRES_LAST) begin
                            r_prescaler <= '0;
                            r_remaining <= r_remaining - TIME_W'(1);
                        end else begin
                            r_prescaler <= r_prescaler + PSW'(1);
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign lights      = r_lights;
    assign phase       = r_phase;
    assign table_sel   = r_table_sel;
    assign remaining   = r_remaining;
    assign phase_start = r_phase_start;
    assign ped_pending = r_ped_pending;
    assign running     = r_running;

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_phase_sequencer
// Purpose  : Self-checking bench for traffic_phase_sequencer. A reference
//            model tracks the duration tables, the pedestrian flag and the
//            active table, and predicts the length and outputs of every
//            phase from the sequencing rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_phase_sequencer;

    localparam int          T    = 4;
    localparam int          NP   = 8;
    localparam logic [8:0]  SAFE = 9'h1A5;

    function automatic logic [8:0] pat(input int p);
        return 9'((p * 37 + 5) % 512);
    endfunction

    function automatic logic [NP*9-1:0] build_lp();
        logic [NP*9-1:0] v;
        v = '0;
        for (int p = 0; p < NP; p++) v[p*9 +: 9] = pat(p);
        return v;
    endfunction

    localparam logic [NP*9-1:0] LP = build_lp();

    logic       CLK = 1'b0;
    logic       reset_general_n;
    logic       enable_general;
    logic [2:0] sensor;
    logic       ped_button;
    logic       ext_ok;
    logic       cfg_we;
    logic [1:0] cfg_table;
    logic [2:0] cfg_phase;
    logic [7:0] cfg_time;
    logic [8:0] lights;
    logic [2:0] phase;
    logic [1:0] table_sel;
    logic [7:0] remaining;
    logic       phase_start;
    logic       ped_pending;
    logic       running;

    traffic_phase_sequencer #(
        .TICKS_PER_SEC (T),
        .LIGHT_PATTERN (LP),
        .SAFE_LIGHTS   (SAFE),
        .HOLD_MASK     (8'b0010_0000)
    ) dut (
        .CLK             (CLK),
        .reset_general_n (reset_general_n),
        .enable_general  (enable_general),
        .sensor          (sensor),
        .ped_button      (ped_button),
        .ext_ok          (ext_ok),
        .cfg_we          (cfg_we),
        .cfg_table       (cfg_table),
        .cfg_phase       (cfg_phase),
        .cfg_time        (cfg_time),
        .lights          (lights),
        .phase           (phase),
        .table_sel       (table_sel),
        .remaining       (remaining),
        .phase_start     (phase_start),
        .ped_pending     (ped_pending),
        .running         (running)
    );

    always #5 CLK = ~CLK;

    // Reference model state
    int m_tab [4][8];
    bit m_ped;
    int m_sel;
    int cyc;
    int n_checks;
    int n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sel_of(input logic [2:0] s);
        case (s)
            3'b001:  return 1;
            3'b010:  return 2;
            3'b100:  return 3;
            default: return 0;
        endcase
    endfunction

    task automatic step();
        @(negedge CLK);
        cyc++;
    endtask

    // Called on the negedge of the first cycle of phase p.
    task automatic enter_check(input int p, output int dur);
        int r;
        if (p == 0) m_sel = sel_of(sensor);
        r = m_tab[m_sel][p] + ((p == 4 && m_ped) ? 10 : 0);
        if (r > 255) r = 255;
        if (p == 4) m_ped = 0;
        chk("entry_start", phase_start, 1);
        chk("entry_phase", phase, p);
        chk("entry_table_sel", table_sel, m_sel);
        chk("entry_remaining", remaining, r);
        chk("entry_lights", lights, pat(p));
        chk("entry_ped_pending", ped_pending, m_ped);
        chk("entry_running", running, 1);
        cyc = 1;
        dur = (r == 0) ? 1 : r * T;
    endtask

    task automatic to_next(input int dur);
        do step(); while (!phase_start && cyc <= dur + 64);
        chk("phase_length", cyc - 1, dur);
    endtask

    task automatic run_phase(input int p, input bit do_wr, input int wt, input int wp,
                             input int wv, input bit do_ped, input bit do_sens,
                             input logic [2:0] sv);
        int dur;
        enter_check(p, dur);
        if (dur >= 2 && (do_wr || do_ped || do_sens)) begin
            if (do_wr) begin
                cfg_we    = 1'b1;
                cfg_table = 2'(wt);
                cfg_phase = 3'(wp);
                cfg_time  = 8'(wv);
                m_tab[wt][wp] = wv;
            end
            if (do_ped) begin
                ped_button = 1'b1;
                m_ped      = 1'b1;
            end
            if (do_sens) sensor = sv;
            step();
            cfg_we     = 1'b0;
            ped_button = 1'b0;
            if (do_ped) chk("ped_latched", ped_pending, 1);
        end
        to_next(dur);
    endtask

    task automatic plain(input int p);
        run_phase(p, 0, 0, 0, 0, 0, 0, 3'b000);
    endtask

    task automatic hold_phase(input int p);
        int dur;
        enter_check(p, dur);
        ext_ok = 1'b0;
        while (cyc < dur + 1) step();
        chk("hold_phase", phase, p);
        chk("hold_remaining", remaining, 0);
        chk("hold_no_start", phase_start, 0);
        repeat (6) step();
        chk("hold_phase_late", phase, p);
        chk("hold_remaining_late", remaining, 0);
        ext_ok = 1'b1;
        to_next(cyc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d;
        reset_general_n = 1'b0;
        enable_general  = 1'b0;
        sensor          = 3'b000;
        ped_button      = 1'b0;
        ext_ok          = 1'b1;
        cfg_we          = 1'b0;
        cfg_table       = '0;
        cfg_phase       = '0;
        cfg_time        = '0;
        for (int t = 0; t < 4; t++) for (int p = 0; p < 8; p++) m_tab[t][p] = 3;
        m_ped = 0; m_sel = 0; cyc = 0; n_checks = 0; n_fail = 0;

        // Reset values
        repeat (3) @(negedge CLK);
        chk("rst_phase", phase, 0);
        chk("rst_table_sel", table_sel, 0);
        chk("rst_remaining", remaining, 0);
        chk("rst_phase_start", phase_start, 0);
        chk("rst_ped_pending", ped_pending, 0);
        chk("rst_running", running, 0);
        chk("rst_lights", lights, SAFE);

        // Release with enable high: phase 0 is entered on the next edge.
        reset_general_n = 1'b1;
        enable_general  = 1'b1;
        step();

        // Cycle A: default 3 s phases; program table 2, then present sensor 1.
        for (int p = 0; p < 8; p++) begin
            if (p == 1)      run_phase(1, 1, 2, 1, 2, 0, 0, 3'b000);
            else if (p == 5) run_phase(5, 0, 0, 0, 0, 0, 1, 3'b010);
            else             plain(p);
        end

        // Cycle B: table 2 active; sensor changes mid-cycle are ignored.
        for (int p = 0; p < 8; p++) begin
            if (p == 2)      run_phase(2, 0, 0, 0, 0, 0, 1, 3'b100);
            else if (p == 6) run_phase(6, 0, 0, 0, 0, 0, 1, 3'b011);
            else             plain(p);
        end

        // Cycle C: two sensors -> table 0; pedestrian extension; hold in phase 5.
        for (int p = 0; p < 8; p++) begin
            if (p == 0)      run_phase(0, 1, 0, 4, 5, 0, 0, 3'b000);
            else if (p == 1) run_phase(1, 0, 0, 0, 0, 1, 0, 3'b000);
            else if (p == 5) hold_phase(5);
            else             plain(p);
        end

        // Cycle D: no extension; write zero duration to the running phase.
        for (int p = 0; p < 8; p++) begin
            if (p == 2) run_phase(2, 1, 0, 2, 0, 0, 0, 3'b000);
            else        plain(p);
        end

        // Cycle E: zero-length phase 2; saturated pedestrian phase.
        for (int p = 0; p < 8; p++) begin
            if (p == 1)      run_phase(1, 1, 0, 4, 255, 1, 0, 3'b000);
            else if (p == 5) run_phase(5, 1, 0, 4, 3, 0, 0, 3'b000);
            else             plain(p);
        end

        // Randomised cycles
        for (int c = 0; c < 5; c++) begin
            for (int p = 0; p < 8; p++) begin
                run_phase(p, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 7)), int'($urandom_range(0, 4)),
                          ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                          3'($urandom_range(0, 7)));
            end
        end

        // Drop enable in phase 3
        for (int p = 0; p < 3; p++) plain(p);
        enter_check(3, d);
        enable_general = 1'b0;
        step();
        chk("idle_running", running, 0);
        chk("idle_phase", phase, 0);
        chk("idle_lights", lights, SAFE);
        chk("idle_phase_start", phase_start, 0);
        chk("idle_ped_kept", ped_pending, m_ped);
        step();
        chk("idle_lights_held", lights, SAFE);

        // Re-enable, then program an entry that reset must wipe.
        enable_general = 1'b1;
        step();
        enter_check(0, d);
        cfg_we = 1'b1; cfg_table = 2'd0; cfg_phase = 3'd6; cfg_time = 8'd1;
        step();
        cfg_we = 1'b0;
        step();

        // Asynchronous reset takes effect without a clock edge.
        reset_general_n = 1'b0;
        #1;
        chk("async_phase", phase, 0);
        chk("async_running", running, 0);
        chk("async_lights", lights, SAFE);
        chk("async_remaining", remaining, 0);
        chk("async_phase_start", phase_start, 0);
        chk("async_ped_pending", ped_pending, 0);
        chk("async_table_sel", table_sel, 0);
        for (int t = 0; t < 4; t++) for (int p = 0; p < 8; p++) m_tab[t][p] = 3;
        m_ped  = 0;
        sensor = 3'b000;
        @(negedge CLK);
        reset_general_n = 1'b1;
        step();
        for (int p = 0; p < 8; p++) plain(p);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
